qlm_pipe: RTL and testbench

Parametrised, pipelined successor to the team's fixed 16-bit truncated logarithmic multiplier. It approximates P = X·Y as follows:
- leading-one detection over the upper operand bits only;
- a Q-bit Mitchell fraction taken from the bits below the leading one;
- log-domain addition, then antilog shift.

It adds a per-transaction sign mode and a 3-stage valid/ready pipeline with backpressure, so it drops into streaming DSP datapaths where the combinational multiplier could not close timing.

---
 rtl/qlm_pipe.sv | 191 +++++++++++++++++++
 tb/tb_qlm_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlm_pipe.sv
// qlm_pipe: pipelined truncated logarithmic (Mitchell) multiplier.
//
// Approximates in_x * in_y in the log domain. The leading one is searched
// only in bits [WIDTH-1:W] of each magnitude, a Q-bit fraction is taken from
// the bits below it, the two logs are added and the antilog is a shift.
// in_mode selects unsigned, one's-complement or two's-complement operands.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (combinational)
//   in_x/in_y  operands, WIDTH bits
//   in_mode    00 unsigned, 01 one's complement, 10/11 two's complement
//   out_valid  product present
//   out_ready  consumer takes the product
//   out_p      product, 2*WIDTH bits
//
// Three register stages (S1 log, S2 sum, S3 product) with a valid bit each;
// a stage advances whenever the stage after it is empty or advancing.

module qlm_pipe #(
    parameter int WIDTH = 16,
    parameter int W     = 6,
    parameter int Q     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int KBW = $clog2(WIDTH);      // leading-one position
    localparam int KW  = $clog2(2*WIDTH);    // summed characteristic
    localparam int PW  = 2*WIDTH;
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << W) - 64'd1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic [1:0]       mode);
        logic [WIDTH-1:0] a;
        case (mode)
            2'b00:   a = v;
            2'b01:   a = v ^ {WIDTH{v[WIDTH-1]}};
            // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
            default: a = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
        endcase
        return a;
    endfunction

    function automatic logic [KBW-1:0] lead_pos(input logic [WIDTH-1:0] a);
        logic [KBW-1:0] k;
        k = '0;
        for (int i = W; i < WIDTH; i++) begin
            if (a[i]) k = KBW'(i);
        end
        return k;
    endfunction

    // Normalise so the leading one sits at the MSB; the Q bits just below it
    // are the fraction. Truncated bits are masked first so they shift in as 0.
    function automatic logic [Q-1:0] mitchell_frac(input logic [WIDTH-1:0] a,
                                                   input logic [KBW-1:0]   k);
        logic [WIDTH-1:0] norm;
        norm = (a & ~LOW_MASK) << (KBW'(WIDTH-1) - k);
        return norm[WIDTH-2 -: Q];
    endfunction

    logic en1, en2, en3;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

    logic [KBW-1:0] kx1_q, kx1_d, ky1_q, ky1_d;
    logic [Q-1:0]   fx1_q, fx1_d, fy1_q, fy1_d;
    logic           z1_q, z1_d, s1_q, s1_d;
    logic [1:0]     m1_q, m1_d;

    logic [KW-1:0]  k2_q, k2_d;
    logic [Q-1:0]   f2_q, f2_d;
    logic           z2_q, z2_d, s2_q, s2_d;
    logic [1:0]     m2_q, m2_d;

    logic [PW-1:0]  out_p_q, out_p_d;

    logic [WIDTH-1:0] ax, ay;
    logic [Q:0]       fsum;
    logic [PW-1:0]    mant, mres;

    always_comb begin
        en3      = ~v3_q | out_ready;
        en2      = ~v2_q | en3;
        en1      = ~v1_q | en2;
        in_ready = en1 & ~rst;

        v1_d = en1 ? (in_valid & in_ready) : v1_q;
        v2_d = en2 ? v1_q : v2_q;
        v3_d = en3 ? v2_q : v3_q;

        // S1: magnitude, leading one, fraction
        ax    = magnitude(in_x, in_mode);
        ay    = magnitude(in_y, in_mode);
        kx1_d = kx1_q;
        ky1_d = ky1_q;
        fx1_d = fx1_q;
        fy1_d = fy1_q;
        z1_d  = z1_q;
        s1_d  = s1_q;
        m1_d  = m1_q;
        if (en1 && in_valid) begin
            kx1_d = lead_pos(ax);
            ky1_d = lead_pos(ay);
            fx1_d = mitchell_frac(ax, kx1_d);
            fy1_d = mitchell_frac(ay, ky1_d);
            z1_d  = ~|(ax & ~LOW_MASK) | ~|(ay & ~LOW_MASK);
            s1_d  = (in_mode != 2'b00) & (in_x[WIDTH-1] ^ in_y[WIDTH-1]);
            m1_d  = in_mode;
        end

        // S2: log-domain sum; the fraction carry bumps the characteristic
        fsum = {1'b0, fx1_q} + {1'b0, fy1_q};
        k2_d = k2_q;
        f2_d = f2_q;
        z2_d = z2_q;
        s2_d = s2_q;
        m2_d = m2_q;
        if (en2 && v1_q) begin
            k2_d = KW'(kx1_q) + KW'(ky1_q) + KW'(fsum[Q]);
            f2_d = fsum[Q-1:0];
            z2_d = z1_q;
            s2_d = s1_q;
            m2_d = m1_q;
        end

        // S3: antilog ({1,F} << K) >> Q, done as a single shift either way
        mant = PW'({1'b1, f2_q});
        if (k2_q >= KW'(Q)) begin
            mres = mant << (k2_q - KW'(Q));
        end else begin
            mres = mant >> (KW'(Q) - k2_q);
        end
        out_p_d = out_p_q;
        if (en3 && v2_q) begin
            if (z2_q) begin
                out_p_d = '0;
            end else begin
                case (m2_q)
                    2'b00:   out_p_d = mres;
                    2'b01:   out_p_d = mres ^ {PW{s2_q}};
                    default: out_p_d = s2_q ? (~mres + PW'(1)) : mres;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            out_p_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            out_p_q <= out_p_d;
        end
    end

    always_ff @(posedge clk) begin
        kx1_q <= kx1_d;
        ky1_q <= ky1_d;
        fx1_q <= fx1_d;
        fy1_q <= fy1_d;
        z1_q  <= z1_d;
        s1_q  <= s1_d;
        m1_q  <= m1_d;
        k2_q  <= k2_d;
        f2_q  <= f2_d;
        z2_q  <= z2_d;
        s2_q  <= s2_d;
        m2_q  <= m2_d;
    end

    assign out_valid = v3_q;
    assign out_p     = out_p_q;

endmodule

// File: tb/tb_qlm_pipe.sv
module tb_qlm_pipe;

    localparam int WIDTH = 16;
    localparam int W     = 6;
    localparam int Q     = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_p;

    qlm_pipe #(.WIDTH(WIDTH), .W(W), .Q(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  m;
        logic [31:0] p;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Reference model written straight from the arithmetic definition.
    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic [1:0] mode);
        logic [15:0] a[2];
        logic        s[2];
        int          k[2];
        int          f[2];
        int          lsum, kk, ff;
        longint      mm;
        logic [31:0] m;
        for (int n = 0; n < 2; n++) begin
            logic [15:0] v;
            v = (n == 0) ? x : y;
            s[n] = (mode != 2'b00) ? v[15] : 1'b0;
            if (mode == 2'b00)      a[n] = v;
            else if (mode == 2'b01) a[n] = v[15] ? ~v : v;
            else                    a[n] = v[15] ? 16'(0 - int'(v)) : v;
            k[n] = -1;
            for (int b = 15; b >= W; b--)
                if (a[n][b] && k[n] < 0) k[n] = b;
            f[n] = 0;
            if (k[n] >= 0)
                for (int i = 0; i < Q; i++)
                    if (k[n] - 1 - i >= W && a[n][k[n]-1-i]) f[n] += (1 << (Q - 1 - i));
        end
        if (k[0] < 0 || k[1] < 0) return 32'h0;
        lsum = (k[0] * (1 << Q) + f[0]) + (k[1] * (1 << Q) + f[1]);
        kk   = lsum / (1 << Q);
        ff   = lsum % (1 << Q);
        mm   = (longint'((1 << Q) + ff) << kk) >> Q;
        m    = mm[31:0];
        if (mode == 2'b01 && (s[0] ^ s[1])) m = ~m;
        if (mode[1] && (s[0] ^ s[1]))       m = 32'(0 - longint'(m));
        return m;
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 16'($urandom_range(0, 127));
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever the DUT hands over a product.
    // A transfer is decided at the negedge because inputs only change just
    // after a posedge, so the values seen here are those the next edge uses.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_p = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", 32'(out_valid), 32'd1);
                    check("stall_hold_data", out_p, prev_p);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_out: got 0x%08h with no beat outstanding", out_p);
                    end else begin
                        check("out_p", out_p, exp_q.pop_front());
                    end
                    n_pops++;
                end
                prev_stall = out_valid && !out_ready;
                prev_p     = out_p;
            end
        end
    end

    // Presents one beat starting just after a posedge and holds it until it
    // is accepted; returns just after the accepting edge.
    task automatic drive(input logic [15:0] x, input logic [15:0] y,
                         input logic [1:0] mode, input logic [31:0] expv);
        bit done;
        done     = 1'b0;
        in_x     = x;
        in_y     = y;
        in_mode  = mode;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL drive_timeout: beat x=0x%04h never accepted", x);
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t dir_v[16];
    vec_t bp_v[5];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx, p0, acc, cyc;
        bit   took, saw;

        dir_v[0]  = '{16'h0300, 16'h0040, 2'b00, 32'h0000C000};
        dir_v[1]  = '{16'h0300, 16'h0300, 2'b00, 32'h00080000};
        dir_v[2]  = '{16'hFF00, 16'h0100, 2'b01, 32'hFFFF3FFF};
        dir_v[3]  = '{16'hFF00, 16'h0100, 2'b10, 32'hFFFF0000};
        dir_v[4]  = '{16'hFF00, 16'h0100, 2'b11, 32'hFFFF0000};
        dir_v[5]  = '{16'h0003, 16'h03E8, 2'b00, 32'h00000000};
        dir_v[6]  = '{16'h0003, 16'h03E8, 2'b01, 32'h00000000};
        dir_v[7]  = '{16'h0003, 16'h03E8, 2'b10, 32'h00000000};
        dir_v[8]  = '{16'h0003, 16'h03E8, 2'b11, 32'h00000000};
        dir_v[9]  = '{16'hFFFF, 16'h0100, 2'b01, 32'h00000000};
        dir_v[10] = '{16'h8000, 16'h0100, 2'b10, 32'hFF800000};
        dir_v[11] = '{16'h8000, 16'h8000, 2'b00, 32'h40000000};
        dir_v[12] = '{16'hFFFF, 16'hFFFF, 2'b00, 32'hF8000000};
        dir_v[13] = '{16'hFF00, 16'hFF00, 2'b10, 32'h00010000};
        dir_v[14] = '{16'h0500, 16'h0A00, 2'b00, 32'h00300000};
        dir_v[15] = '{16'h0100, 16'hFE00, 2'b01, 32'hFFFE3FFF};

        bp_v[0] = '{16'h1234, 16'h0456, 2'b00, 32'h0};
        bp_v[1] = '{16'hF123, 16'h7FFF, 2'b01, 32'h0};
        bp_v[2] = '{16'h8000, 16'hC000, 2'b10, 32'h0};
        bp_v[3] = '{16'h00C0, 16'hABCD, 2'b11, 32'h0};
        bp_v[4] = '{16'h7777, 16'h0888, 2'b00, 32'h0};

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_p", out_p, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // basic beat and latency: the accepting edge is the first of three
        @(posedge clk);
        #1;
        drive(16'h0100, 16'h0100, 2'b01, 32'h00010000);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge3_valid", 32'(out_valid), 32'd1);

        // directed vectors, back to back
        @(posedge clk);
        #1;
        foreach (dir_v[i]) drive(dir_v[i].x, dir_v[i].y, dir_v[i].m, dir_v[i].p);
        in_valid = 1'b0;
        wait_drain();

        // backpressure: consumer stalled for six cycles
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_x      = bp_v[idx].x;
            in_y      = bp_v[idx].y;
            in_mode   = bp_v[idx].m;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(bp_v[idx].x, bp_v[idx].y, bp_v[idx].m));
                idx++;
            end
        end
        check("bp_accepted", 32'(idx), 32'd3);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        p0 = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                out_ready = 1'b1;
                p0 = n_pops;
            end
            if (idx < 5) begin
                in_valid = 1'b1;
                in_x     = bp_v[idx].x;
                in_y     = bp_v[idx].y;
                in_mode  = bp_v[idx].m;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(bp_v[idx].x, bp_v[idx].y, bp_v[idx].m));
                idx++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'd5);
        check("bp_back_to_back", 32'(n_pops - p0), 32'd5);
        wait_drain();

        // reset with two beats in flight
        drive(16'h0300, 16'h0300, 2'b00, model(16'h0300, 16'h0300, 2'b00));
        drive(16'h0400, 16'h0500, 2'b00, model(16'h0400, 16'h0500, 2'b00));
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("ready_during_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_flush", 32'(in_ready), 32'd1);
        check("out_p_after_flush", out_p, 32'h0);
        saw = out_valid;
        repeat (5) begin
            @(negedge clk);
            saw = saw | out_valid;
        end
        check("flushed_beats_absent", 32'(saw), 32'd0);

        // random traffic against the model
        acc  = 0;
        cyc  = 0;
        took = 1'b0;
        in_valid = 1'b0;
        while (acc < 10000 && cyc < 60000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (took) in_valid = 1'b0;
            took      = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_x     = rand_op();
                in_y     = rand_op();
                in_mode  = 2'($urandom_range(0, 3));
                in_valid = 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_x, in_y, in_mode));
                acc++;
                took = 1'b1;
            end
        end
        check("random_beats_accepted", 32'(acc), 32'd10000);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
